hazard_scoreboard: RTL

Parametrised successor to the decode-stage hazard detector. It tracks every in-flight register write in a shift-register scoreboard, with up to two destinations per instruction (e.g. STU base writeback). It stalls decode on read-after-write hazards, cancels wrong-path entries on a control-flow redirect, and runs a multi-cycle fetch-flush sequence. It sits beside the IF/ID and ID/EX pipeline registers and drives their stall/flush controls.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage and the hazard scoreboard:
// decode operands, redirect, and the stall/issue/flush/busy controls.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 3
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs_addr;
    logic [REG_ADDR_W-1:0] id_rt_addr;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic [REG_ADDR_W-1:0] id_d0_addr;
    logic [REG_ADDR_W-1:0] id_d1_addr;
    logic                  id_d0_wr;
    logic                  id_d1_wr;
    logic                  pc_redirect;
    logic                  stall_decode;
    logic                  issue;
    logic                  flush_fetch;
    logic [NUM_REGS-1:0]   busy_mask;
    logic [15:0]           stall_count;

    // Decode stage / pipeline control side
    modport master (
        output id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_d0_addr, id_d1_addr, id_d0_wr, id_d1_wr, pc_redirect,
        input  stall_decode, issue, flush_fetch, busy_mask, stall_count
    );

    // Scoreboard side
    modport slave (
        input  id_valid, id_rs_addr, id_rt_addr, id_rs_used, id_rt_used,
               id_d0_addr, id_d1_addr, id_d0_wr, id_d1_wr, pc_redirect,
        output stall_decode, issue, flush_fetch, busy_mask, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight register writes (up to two
// destinations per instruction) in a shift register, stalls decode on RAW
// hazards, cancels young wrong-path entries on redirect and sequences the
// multi-cycle fetch flush.
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 3,
    parameter int WB_LAT       = 3,
    parameter int KILL_DEPTH   = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int RF_BYPASS    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_W;
    // With a bypassing register file the slot writing this cycle is not a hazard
    localparam int WIN      = (RF_BYPASS != 0) ? WB_LAT - 1 : WB_LAT;
    localparam int CNT_W    = $clog2(FLUSH_CYCLES) + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef struct packed {
        logic                  d0_wr;
        logic [REG_ADDR_W-1:0] d0_addr;
        logic                  d1_wr;
        logic [REG_ADDR_W-1:0] d1_addr;
    } slot_t;

    slot_t               r_slot [WB_LAT];
    logic [0:0]          r_state;
    logic [CNT_W-1:0]    r_flush_cnt;
    logic [15:0]         r_stall_count;

    slot_t               w_dec_rec;
    logic [NUM_REGS-1:0] w_pending;
    logic                w_stall;
    logic                w_issue;
    logic                w_flush_active;

    assign w_dec_rec = '{d0_wr:   bus.id_d0_wr,
                         d0_addr: bus.id_d0_addr,
                         d1_wr:   bus.id_d1_wr,
                         d1_addr: bus.id_d1_addr};

    // Per-register pending-write flags from the slots inside the busy window
    always_comb begin
        // NOTE: default first so every path assigns w_pending and no latch is inferred.
        w_pending = '0;
        for (int k = 0; k < WIN; k++) begin
            if (r_slot[k].d0_wr) w_pending[r_slot[k].d0_addr] = 1'b1;
            if (r_slot[k].d1_wr) w_pending[r_slot[k].d1_addr] = 1'b1;
        end
    end

    assign w_flush_active = (r_state == ST_FLUSH);
    // Only sources are compared; the decode instruction's own destinations never stall it
    assign w_stall = bus.id_valid &
                     ((bus.id_rs_used & w_pending[bus.id_rs_addr]) |
                      (bus.id_rt_used & w_pending[bus.id_rt_addr]));
    assign w_issue = bus.id_valid & ~w_stall & ~bus.pc_redirect & ~w_flush_active;

    assign bus.stall_decode = w_stall;
    assign bus.issue        = w_issue;
    assign bus.flush_fetch  = bus.pc_redirect | w_flush_active;
    assign bus.busy_mask    = w_pending;
    assign bus.stall_count  = r_stall_count;

    // Scoreboard shift: new record enters slot 0, redirect empties the youngest slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the slots are a handful of flops, not a RAM; clearing them on reset
            // is what guarantees busy_mask and stall_decode come out of reset at zero.
            for (int k = 0; k < WB_LAT; k++) r_slot[k] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every slot shifts from its pre-edge neighbour.
            r_slot[0] <= w_issue ? w_dec_rec : '0;
            for (int k = 1; k < WB_LAT; k++) begin
                if (bus.pc_redirect && (k <= KILL_DEPTH)) r_slot[k] <= '0;
                else                                      r_slot[k] <= r_slot[k-1];
            end
        end
    end

    // Flush sequencer: holds flush_fetch for FLUSH_CYCLES-1 cycles after a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.pc_redirect && (FLUSH_CYCLES > 1)) begin
                        r_state     <= ST_FLUSH;
                        r_flush_cnt <= CNT_RELOAD;
                    end
                end
                ST_FLUSH: begin
                    if (bus.pc_redirect) begin
                        r_flush_cnt <= CNT_RELOAD;
                    end else if (r_flush_cnt == CNT_ONE) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - CNT_ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of cycles in which decode was stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end
endmodule
